// File: rtl/countdown_sequencer.sv
// Countdown command sequencer: drives a generic register through load, per-tick
// decrement, detonate/disarm and clear, and reports the countdown status.
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 2
`endif
`ifndef REG_CTRL_NOP
`define REG_CTRL_NOP 2'b00
`endif
`ifndef REG_CTRL_CLR
`define REG_CTRL_CLR 2'b01
`endif
`ifndef REG_CTRL_LD
`define REG_CTRL_LD 2'b10
`endif
`ifndef REG_CTRL_DEC
`define REG_CTRL_DEC 2'b11
`endif

module countdown_sequencer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000000
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           load_value,
  input  logic [WIDTH-1:0]           reg_value,
  output logic [`REG_CTRL_WIDTH-1:0] reg_ctrl,
  output logic [WIDTH-1:0]           reg_data,
  output logic                       armed,
  output logic                       detonated,
  output logic                       disarmed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESCALE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESCALE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] VALUE_ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    FIRED    = 2'd2,
    DISARMED = 2'd3
  } state_t;

  state_t                     state, state_next;
  logic [PW-1:0]              prescaler, prescaler_next;
  logic [`REG_CTRL_WIDTH-1:0] ctrl_next;
  logic [WIDTH-1:0]           data_next;
  logic                       tick;

  assign tick = (prescaler == PRESCALE_LAST);

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state     <= IDLE;
      prescaler <= '0;
      reg_ctrl  <= `REG_CTRL_NOP;
      reg_data  <= '0;
      armed     <= 1'b0;
      detonated <= 1'b0;
      disarmed  <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      reg_ctrl  <= ctrl_next;
      reg_data  <= data_next;
      armed     <= (state_next == ARMED);
      detonated <= (state_next == FIRED);
      disarmed  <= (state_next == DISARMED);
    end
  end

  // Priority while counting is clear > disarm > tick; commands last one cycle.
  always_comb begin
    state_next     = state;
    prescaler_next = '0;
    ctrl_next      = `REG_CTRL_NOP;
    data_next      = reg_data;
    case (state)
      IDLE: begin
        if (clear) begin
          ctrl_next = `REG_CTRL_CLR;
        end else if (arm && (load_value != '0)) begin
          ctrl_next  = `REG_CTRL_LD;
          data_next  = load_value;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (clear) begin
          ctrl_next  = `REG_CTRL_CLR;
          state_next = IDLE;
        end else if (disarm) begin
          state_next = DISARMED;
        end else if (tick) begin
          if (reg_value != '0) ctrl_next = `REG_CTRL_DEC;
          if (reg_value <= VALUE_ONE) state_next = FIRED;
        end
        if (state_next == ARMED) prescaler_next = tick ? '0 : prescaler + PRESCALE_ONE;
      end
      FIRED, DISARMED: begin
        if (clear) begin
          ctrl_next  = `REG_CTRL_CLR;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
